// File: rtl/tdm_frame_scheduler_if.sv
// rtl/tdm_frame_scheduler_if.sv - sample stream handshake between sample FIFO and TDM scheduler
interface tdm_frame_scheduler_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/tdm_frame_scheduler.sv
// rtl/tdm_frame_scheduler.sv - TDM lane sequencer: bit/slot/frame counting, fsync, MSB-first sdata (option: TDM_FSYNC_HALF_EN)
module tdm_frame_scheduler #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 bclk_tick,
   input  logic [2:0]           tdm_num,
   input  logic [1:0]           slot_width,
   tdm_frame_scheduler_if.slave s_axis,
   output logic                 sdata,
   output logic                 fsync,
   output logic [3:0]           slot_idx,
   output logic                 frame_start,
   output logic                 underrun,
   output logic                 busy
);

   typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;

   state_t      state_q, state_d;
   logic [3:0]  n_m1;        // latched slot count minus one
   logic [4:0]  w_m1;        // latched slot width minus one
   logic [4:0]  bit_cnt;
   logic [31:0] shift_reg;
   logic [3:0]  dec_n_m1;
   logic [4:0]  dec_w_m1;
   logic [4:0]  ld_w_m1;
   logic [3:0]  next_slot;
   logic [31:0] sample;
   logic        slot_end, frame_end;
   logic        load, start_frame, stop;

   // Only the low 32 bits carry the right-aligned sample.
   if (DATA_WIDTH > 32) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^s_axis.tdata[DATA_WIDTH-1:32];
   end

   assign sample    = s_axis.tdata[31:0];
   assign slot_end  = (bit_cnt == w_m1);
   assign frame_end = slot_end && (slot_idx == n_m1);
   // A new frame picks up freshly decoded geometry; mid-frame slots keep the latched one.
   assign ld_w_m1   = start_frame ? dec_w_m1 : w_m1;
   assign next_slot = start_frame ? 4'd0 : slot_idx + 4'd1;
   assign s_axis.tready = load;
   assign busy      = (state_q != IDLE);

   // Decode the register-encoded slot count and slot width.
   always_comb begin
      case (tdm_num)
         3'd2:    dec_n_m1 = 4'd3;
         3'd3:    dec_n_m1 = 4'd7;
         3'd4:    dec_n_m1 = 4'd15;
         default: dec_n_m1 = 4'd1;
      endcase
      case (slot_width)
         2'd0:    dec_w_m1 = 5'd15;
         2'd1:    dec_w_m1 = 5'd23;
         default: dec_w_m1 = 5'd31;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and per-tick actions: slot load, frame restart, stop at frame end.
   always_comb begin
      state_d     = state_q;
      load        = 1'b0;
      start_frame = 1'b0;
      stop        = 1'b0;
      case (state_q)
         IDLE: if (enable) state_d = ARM;
         ARM: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (bclk_tick) begin
               state_d     = RUN;
               load        = 1'b1;
               start_frame = 1'b1;
            end
         end
         RUN: begin
            if (bclk_tick) begin
               if (frame_end && !enable) begin
                  state_d = IDLE;
                  stop    = 1'b1;
               end else if (slot_end) begin
                  load        = 1'b1;
                  start_frame = frame_end;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Tick-driven datapath: counters, shifter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_m1        <= 4'd0;
         w_m1        <= 5'd0;
         bit_cnt     <= 5'd0;
         shift_reg   <= 32'd0;
         sdata       <= 1'b0;
         fsync       <= 1'b0;
         slot_idx    <= 4'd0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else if (stop) begin
         bit_cnt     <= 5'd0;
         shift_reg   <= 32'd0;
         sdata       <= 1'b0;
         fsync       <= 1'b0;
         slot_idx    <= 4'd0;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
      end else if (load) begin
         bit_cnt     <= 5'd0;
         slot_idx    <= next_slot;
         frame_start <= start_frame;
         if (start_frame) begin
            n_m1 <= dec_n_m1;
            w_m1 <= dec_w_m1;
         end
         if (s_axis.tvalid) begin
            sdata     <= sample[ld_w_m1];
            shift_reg <= sample << 1;
            underrun  <= 1'b0;
         end else begin
            sdata     <= 1'b0;
            shift_reg <= 32'd0;
            underrun  <= 1'b1;
         end
`ifdef TDM_FSYNC_HALF_EN
         // LRCK-style: high for the first half of the slots.
         fsync <= ({1'b0, next_slot} <
                   (({1'b0, (start_frame ? dec_n_m1 : n_m1)} + 5'd1) >> 1));
`else
         fsync <= start_frame;
`endif
      end else if (state_q == RUN && bclk_tick) begin
         bit_cnt     <= bit_cnt + 5'd1;
         sdata       <= shift_reg[w_m1];
         shift_reg   <= shift_reg << 1;
         frame_start <= 1'b0;
         underrun    <= 1'b0;
`ifndef TDM_FSYNC_HALF_EN
         fsync       <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_tdm_frame_scheduler.sv
// tb/tb_tdm_frame_scheduler.sv - self-checking bench for tdm_frame_scheduler
module tb_tdm_frame_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       bclk_tick;
   logic [2:0] tdm_num;
   logic [1:0] slot_width;
   logic       sdata, fsync, frame_start, underrun, busy;
   logic [3:0] slot_idx;

   tdm_frame_scheduler_if #(.DATA_WIDTH(32)) s_if ();

   tdm_frame_scheduler #(.DATA_WIDTH(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .bclk_tick   (bclk_tick),
      .tdm_num     (tdm_num),
      .slot_width  (slot_width),
      .s_axis      (s_if.slave),
      .sdata       (sdata),
      .fsync       (fsync),
      .slot_idx    (slot_idx),
      .frame_start (frame_start),
      .underrun    (underrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] tdm_num;
      logic [1:0] slot_width;
      int         exp_n;
      int         exp_w;
   } vec_t;

   vec_t        vecs [8];
   logic [31:0] samp [4];
   int          n_checks = 0;
   int          n_err    = 0;
   int          ptr      = 0;   // samples actually transferred to the DUT
   int          eptr     = 0;   // samples the bench expects to have been consumed
   logic        rdy;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] mask(input int w);
      logic [31:0] m;
      if (w == 32) m = 32'hFFFF_FFFF;
      else         m = (32'h1 << w) - 32'h1;
      return m;
   endfunction

   // One clock: drive at negedge, capture tready, clock, land on next negedge.
   task automatic step(input logic tick, input logic valid);
      logic xfer;
      bclk_tick   = tick;
      s_if.tvalid = valid;
      s_if.tdata  = samp[ptr % 4];
      #1;
      rdy  = s_if.tready;
      xfer = rdy && valid;
      @(posedge clk);
      if (xfer) ptr++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      enable = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ptr   = 0;
      eptr  = 0;
   endtask

   // Runs one frame tick by tick and checks every output against the bench's own expectation.
   task automatic run_frame(input int n, input int w, input int uslot, input int drop_at,
                            input int chg_at, input logic [2:0] chg_val, input int gate_at);
      logic [31:0] esamp = 32'd0;
      int          slot, bitn;
      logic        force_inv, exp_fs;
      for (int k = 0; k < n * w; k++) begin
         slot = k / w;
         bitn = k % w;
         if (k == drop_at) enable = 1'b0;
         if (k == chg_at)  tdm_num = chg_val;
         if (k == gate_at) begin
            for (int g = 0; g < 3; g++) begin
               step(1'b0, 1'b1);
               chk("gate_tready", rdy, 0);
               chk("gate_slot", slot_idx, (k - 1) / w);
               chk("gate_sdata", sdata, esamp[w - 1 - ((k - 1) % w)]);
            end
         end
         force_inv = (bitn == 0) && (slot == uslot);
         if (bitn == 0) begin
            if (force_inv) esamp = 32'd0;
            else begin
               esamp = samp[eptr % 4] & mask(w);
               eptr++;
            end
         end
         step(1'b1, !force_inv);
         chk("tready", rdy, int'(bitn == 0));
         chk("sdata", sdata, esamp[w - 1 - bitn]);
         chk("slot_idx", slot_idx, slot);
         chk("frame_start", frame_start, int'(k == 0));
`ifdef TDM_FSYNC_HALF_EN
         exp_fs = (slot < n / 2);
`else
         exp_fs = (k == 0);
`endif
         chk("fsync", fsync, exp_fs);
         chk("underrun", underrun, force_inv);
         chk("busy", busy, 1);
      end
   endtask

   task automatic check_idle(input string tag);
      step(1'b1, 1'b1);
      chk({tag, "_tready"}, rdy, 0);
      chk({tag, "_sdata"}, sdata, 0);
      chk({tag, "_fsync"}, fsync, 0);
      chk({tag, "_slot"}, slot_idx, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_fstart"}, frame_start, 0);
   endtask

   initial begin
      samp[0] = 32'h3C5A_A5A5;
      samp[1] = 32'h00FF_0001;
      samp[2] = 32'hF0F0_8000;
      samp[3] = 32'h1234_FFFF;
      vecs[0] = '{3'd2, 2'd0, 4, 16};
      vecs[1] = '{3'd0, 2'd0, 2, 16};
      vecs[2] = '{3'd1, 2'd1, 2, 24};
      vecs[3] = '{3'd2, 2'd2, 4, 32};
      vecs[4] = '{3'd3, 2'd0, 8, 16};
      vecs[5] = '{3'd4, 2'd3, 16, 32};
      vecs[6] = '{3'd7, 2'd3, 2, 32};
      vecs[7] = '{3'd5, 2'd1, 2, 24};

      rst_n       = 1'b0;
      enable      = 1'b0;
      bclk_tick   = 1'b0;
      tdm_num     = 3'd0;
      slot_width  = 2'd0;
      s_if.tvalid = 1'b0;
      s_if.tdata  = 32'd0;

      // Reset state.
      @(negedge clk);
      chk("rst_sdata", sdata, 0);
      chk("rst_fsync", fsync, 0);
      chk("rst_slot", slot_idx, 0);
      chk("rst_fstart", frame_start, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tready", s_if.tready, 0);
      rst_n = 1'b1;

      // Ticks while IDLE are ignored.
      for (int i = 0; i < 3; i++) check_idle("idle_tick");

      // Geometry decode table: two consecutive frames per entry.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         tdm_num    = vecs[i].tdm_num;
         slot_width = vecs[i].slot_width;
         enable     = 1'b1;
         step(1'b1, 1'b1);
         chk("arm_tready", rdy, 0);
         chk("arm_busy", busy, 1);
         run_frame(vecs[i].exp_n, vecs[i].exp_w, -1, -1, -1, 3'd0, (i == 0) ? 5 : -1);
         run_frame(vecs[i].exp_n, vecs[i].exp_w, -1, -1, -1, 3'd0, -1);
      end

      // Underrun at slot 1 of the second frame; slot 2 reloads normally.
      do_reset();
      tdm_num = 3'd2; slot_width = 2'd0; enable = 1'b1;
      step(1'b1, 1'b1);
      run_frame(4, 16, -1, -1, -1, 3'd0, -1);
      run_frame(4, 16, 1, -1, -1, 3'd0, -1);
      run_frame(4, 16, -1, -1, -1, 3'd0, -1);

      // Slot count changed mid-frame only takes effect next frame.
      do_reset();
      tdm_num = 3'd1; slot_width = 2'd0; enable = 1'b1;
      step(1'b1, 1'b1);
      run_frame(2, 16, -1, -1, 5, 3'd4, -1);
      run_frame(16, 16, -1, -1, -1, 3'd0, -1);

      // enable drops in slot 0: frame finishes, then IDLE with no further loads.
      do_reset();
      tdm_num = 3'd1; slot_width = 2'd1; enable = 1'b1;
      step(1'b1, 1'b1);
      run_frame(2, 24, -1, 3, -1, 3'd0, -1);
      check_idle("drop_end");
      check_idle("drop_after");

      // Asynchronous reset in slot 3, then restart.
      do_reset();
      tdm_num = 3'd2; slot_width = 2'd0; enable = 1'b1;
      step(1'b1, 1'b1);
      for (int k = 0; k < 50; k++) step(1'b1, 1'b1);
      chk("mid_slot", slot_idx, 3);
      chk("mid_sdata", sdata, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_sdata", sdata, 0);
      chk("arst_fsync", fsync, 0);
      chk("arst_slot", slot_idx, 0);
      chk("arst_fstart", frame_start, 0);
      chk("arst_underrun", underrun, 0);
      chk("arst_busy", busy, 0);
      chk("arst_tready", s_if.tready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ptr   = 0;
      eptr  = 0;
      step(1'b1, 1'b1);
      run_frame(4, 16, -1, -1, -1, 3'd0, -1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/tdm_frame_scheduler.md
Name: tdm_frame_scheduler

Overview:
Sequences one TDM serial output lane: counts bit-clock ticks into bits, slots and frames, and drives frame sync and MSB-first serial data. Pulls one sample per slot from an upstream AXI-Stream-style buffer. Decodes the 3-bit TDM slot-count register internally using the i2s encoding 1→2, 2→4, 3→8, 4→16, other→2. Sits between the i2s register block / sample FIFO and the pad-side serializer, clocked in the system domain with a bclk_tick strobe from the clock divider.

Parameters:
DATA_WIDTH, 32, width of s_axis_tdata; must be ≥ 32.

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
enable  input  1  start/continue framing; deassertion takes effect at frame end
bclk_tick  input  1  one-cycle strobe, one bit period per tick
tdm_num  input  3  encoded slot count: 1→2, 2→4, 3→8, 4→16, other→2
slot_width  input  2  0→16 bits, 1→24 bits, 2/3→32 bits
s_axis_tdata  input  DATA_WIDTH  sample, right-aligned: MSB at bit W-1
s_axis_tvalid  input  1  sample available
s_axis_tready  output  1  combinational; sample consumed this cycle
sdata  output  1  serial data, MSB first
fsync  output  1  frame sync
slot_idx  output  4  current slot
frame_start  output  1  one-cycle pulse at slot 0, bit 0
underrun  output  1  one-cycle pulse when a slot loads with tvalid low
busy  output  1  high in ARM and RUN

Behaviour:
- Reset (async, rst_n=0): state IDLE; sdata, fsync, slot_idx, frame_start, underrun, busy, all counters = 0; combinational s_axis_tready = 0. Takes effect immediately, including mid-frame.
- States: IDLE → ARM when enable=1. ARM → RUN on the first bclk_tick. RUN → IDLE at frame end when enable=0.
- Config latch: tdm_num is decoded to N and slot_width to W only in ARM and at each frame boundary. Changes mid-frame are ignored until the next frame.
- All outputs except s_axis_tready are registered and update on the clk edge that samples bclk_tick=1. Nothing changes on cycles without a tick.
- Slot load: occurs on a tick that starts a new slot (ARM's first tick, or bit_cnt==W-1 in RUN with the frame continuing).
  - s_axis_tready=1 that cycle; the transfer happens iff tvalid=1.
  - If tvalid=0, the shifter loads 0 and underrun pulses.
- Shifter: sdata = shifter bit W-1 of the loaded sample; shifts left one bit per tick.
- Counters: bit_cnt runs 0..W-1. slot_idx increments when bit_cnt wraps, and wraps N-1 → 0 (frame boundary).
  - frame_start and fsync are set on the tick entering slot 0, bit 0.
  - fsync clears on the next tick (one bit wide).
- Frame end with enable=0: on the final tick of slot N-1, go to IDLE; sdata=0, fsync=0, slot_idx=0, busy=0; no slot load; tready stays low.
- enable=0 in ARM: return to IDLE without a load.
- bclk_tick while IDLE: ignored.

Optional Feature:
TDM_FSYNC_HALF_EN
- Defined: fsync is high for slots 0..N/2-1 and low for the remaining slots (50% duty, I2S-style LRCK).
- Undefined: fsync is one bit wide at slot 0, bit 0.

Test Plan:
- Reset mid-frame: assert rst_n=0 during slot 3 → all outputs 0 in the same cycle; restart with enable=1 → frame_start on the first tick.
- tdm_num=2, slot_width=0, tvalid always 1, samples 0xA5A5, 0x0001, 0x8000, 0xFFFF → sdata matches MSB-first over 64 ticks; slot_idx 0..3; fsync high ticks 0 and 64; 4 tready transfers per frame.
- tdm_num=7 (default), slot_width=3 → N=2, W=32; frame_start every 64 ticks.
- tvalid=0 at slot 1 load → underrun pulses once; slot 1 sdata all 0; slot 2 loads normally.
- Change tdm_num 1→4 in mid-frame 0 → frame 0 keeps 2 slots; frame 1 has 16 slots, slot_idx reaches 15.
- enable drops in slot 0 of N=2, W=24 → frame completes (48 ticks) then IDLE, busy=0; no extra tready. With TDM_FSYNC_HALF_EN, fsync is high for the first 24 ticks.
